pdm_led_display: RTL and testbench
==================================

# pdm_led_display

Two-channel pulse-density-modulated (PDM) LED display block for the iCE40UP5K board top level. Channel A modulates an internal 10-bit down-sawtooth and channel B modulates an external 10-bit sample. The block drives the resulting bitstreams onto two fixed pixels of the 4×4 multiplexed LED matrix through anode lines and cathode tristate enables. It sits between the HFOSC-derived system clock and the SB_IO cathode pads; the pads are driven high with OUTPUT_ENABLE taken from `kled_tri`.

## Interface

**Parameters**

- `NBITS`, 10: sample/error width.
- `CLKDIV`, 46: saw step period minus one, in clocks. The saw holds each value for CLKDIV+1 cycles.
- `LED_A`, 5: matrix index (0–15) showing channel A.
- `LED_B`, 10: matrix index showing channel B. Must differ from LED_A.

**Ports**

- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: system clock (48 MHz HFOSC).
- `rst` in 1: async active-high reset.
- `din_b` in NBITS: channel B sample, unsigned.
- `saw_out` out NBITS: registered sawtooth value feeding channel A.
- `pdm_a`, `pdm_b` out 1: PDM bitstreams.
- `err_a`, `err_b` out NBITS: modulator error accumulators.
- `aled` out 4: anode lines, active-low column select.
- `kled_tri` out 4: cathode output enables, one-hot row or 0.

## Operation

**Reset values (all asynchronous)**

- Saw: `amp`=2^NBITS−1, step counter 0, `saw_out`=2^NBITS−1.
- Each PDM: `din_reg`, `error`, `error_0`, `error_1` = 0 and `dout` = 0.
- `ledbits` = 0.
- Scan counter = 0, `aled`=4'b1111, `kled_tri`=4'b0000.

**Saw generator**

- The step counter increments while it is below CLKDIV.
- When it equals CLKDIV, the counter goes to 0 and `amp` decrements.
- When `amp` is 0, it wraps to 2^NBITS−1 instead of decrementing.
- `saw_out` <= `amp` every cycle.

**PDM modulator (one instance per channel)**

- Channel A input is `saw_out`; channel B input is `din_b`. The two instances are identical.
- Every cycle:
  - `din_reg` <= din.
  - `error_1` <= error + (2^NBITS−1) − `din_reg`.
  - `error_0` <= error − `din_reg`.
  - All sums are modulo 2^NBITS.
- Same cycle:
  - If `din_reg` >= error: `dout`<=1 and error<=`error_1`.
  - Otherwise: `dout`<=0 and error<=`error_0`.
- `error_0` and `error_1` use the previous-cycle error. This one-stage pipelined feedback is required bit-exactly; it is not a textbook first-order modulator.

**Display mapping**

- Every cycle, `ledbits` is rebuilt: bit LED_A <= `pdm_a`, bit LED_B <= `pdm_b`, all other bits 0.

**Matrix scan**

- A 9-bit scan counter increments every cycle and wraps.
- When counter[4:0]==15 (the strobe), with k = counter[8:5]:
  - `kled_tri` <= `ledbits`[k] ? (1<<k[3:2]) : 0.
  - `aled` <= ~(1<<k[1:0]).
- So k[3:2] selects the row and cathode, and k[1:0] selects the column and anode.
- Each index is displayed for 32 cycles; a full frame is 512 cycles.

## Timing

- `din_b` to `din_reg`: 1 cycle. `din_reg` affects `pdm_b` at the following edge, so input-to-output latency is 2 cycles.
- `amp` to `saw_out`: 1 cycle. Total saw-to-`pdm_a` latency is 3 cycles.
- `pdm_x` to `ledbits`: 1 cycle. Matrix outputs change only at the edge following a strobe cycle (counter[4:0]==15).
- First strobe is at counter=15, so `aled`/`kled_tri` first update at the 16th edge after reset release, using index 0.
- Index k outputs become valid after the edge at counter = 32k+15 and hold for 32 cycles.
- Reset asserted mid-frame forces all reset values immediately, without waiting for a clock edge.
- Scan restarts at index 0 on reset release.
- No handshakes; all paths are free-running.

## Test plan

- **Reset:** assert `rst` between edges.
  - Response: `aled`=1111, `kled_tri`=0000, `saw_out`=1023, `pdm_a`/`pdm_b`=0 and `err_a`/`err_b`=0, all without a clock edge.
- **Saw (CLKDIV=3):** release reset.
  - `amp` steps 1023→1022 after 4 cycles, then decrements every 4 cycles.
  - It reaches 0 and wraps to 1023 after 1024 steps (4096 cycles).
  - `saw_out` trails `amp` by 1 cycle.
- **PDM, `din_b`=0:**
  - `pdm_b` on edges 1..8 after release = 1,1,0,1,0,1,0,1.
  - `err_b` on edges 1..6 = 0,1023,0,1022,0,1021.
- **PDM, `din_b`=1023:** `pdm_b`=1 on every edge from edge 1 after release; never 0.
- **Scan, `din_b`=1023:**
  - After edge 336 (index 10): `kled_tri`=0100, `aled`=1011 for 32 cycles.
  - Indices other than LED_A/LED_B: `kled_tri`=0000 with `aled` cycling 1110,1101,1011,0111.
- **Mid-frame reset:** pulse `rst` at counter=200.
  - Outputs return to reset values immediately.
  - After release, the first update is at edge 16, using index 0.

Source files
------------

// File: rtl/pdm_led_display_if.sv
// Output bundle of the two-channel PDM LED display: channel B sample in,
// saw/PDM/error observation and LED matrix drive out.
interface pdm_led_display_if #(
    parameter int unsigned NBITS = 10
);
    logic [NBITS-1:0] din_b;
    logic [NBITS-1:0] saw_out;
    logic             pdm_a;
    logic             pdm_b;
    logic [NBITS-1:0] err_a;
    logic [NBITS-1:0] err_b;
    logic [3:0]       aled;
    logic [3:0]       kled_tri;

    modport master (
        output din_b,
        input  saw_out, pdm_a, pdm_b, err_a, err_b, aled, kled_tri
    );

    modport slave (
        input  din_b,
        output saw_out, pdm_a, pdm_b, err_a, err_b, aled, kled_tri
    );
endinterface

// File: rtl/pdm_led_display.sv
// Two-channel PDM LED display: channel A modulates an internal down-sawtooth,
// channel B an external sample; both bitstreams are scanned onto a 4x4 matrix.
module pdm_led_display #(
    parameter int unsigned NBITS  = 10,
    parameter int unsigned CLKDIV = 46,
    parameter int unsigned LED_A  = 5,
    parameter int unsigned LED_B  = 10
) (
    input  logic               clk,
    input  logic               rst,
    pdm_led_display_if.slave   disp_if
);

    localparam int unsigned CW   = (CLKDIV > 0) ? $clog2(CLKDIV + 1) : 1;
    localparam int unsigned NCH  = 2;
    localparam int unsigned SW   = 9;
    localparam logic [NBITS-1:0] MAXV = {NBITS{1'b1}};

    // Sawtooth generator state
    logic [CW-1:0]    step_q, step_d;
    logic [NBITS-1:0] amp_q,  amp_d;
    logic [NBITS-1:0] saw_q,  saw_d;

    // Per-channel modulator inputs and observed outputs
    logic [NBITS-1:0] din_c [NCH];
    logic [NBITS-1:0] err_w [NCH];
    logic             dout_w [NCH];

    // Display mapping and matrix scan
    logic [15:0]      ledbits_q, ledbits_d;
    logic [SW-1:0]    scan_q,    scan_d;
    logic [3:0]       aled_q,    aled_d;
    logic [3:0]       kled_q,    kled_d;
    logic [3:0]       k_c;

    // Saw holds each amplitude for CLKDIV+1 cycles and wraps 0 -> max
    always_comb begin
        step_d = step_q + CW'(1);
        amp_d  = amp_q;
        saw_d  = amp_q;
        if (step_q == CW'(CLKDIV)) begin
            step_d = '0;
            amp_d  = (amp_q == '0) ? MAXV : amp_q - NBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            amp_q  <= MAXV;
            saw_q  <= MAXV;
        end else begin
            step_q <= step_d;
            amp_q  <= amp_d;
            saw_q  <= saw_d;
        end
    end

    assign din_c[0] = saw_q;
    assign din_c[1] = disp_if.din_b;

    // Both candidate errors are formed from the previous error, so the
    // comparison selects a value one update stale by design.
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [NBITS-1:0] din_reg_q, din_reg_d;
        logic [NBITS-1:0] err_q,     err_d;
        logic [NBITS-1:0] err0_q,    err0_d;
        logic [NBITS-1:0] err1_q,    err1_d;
        logic             dout_q,    dout_d;

        always_comb begin
            din_reg_d = din_c[ch];
            err1_d    = err_q + MAXV - din_reg_q;
            err0_d    = err_q - din_reg_q;
            dout_d    = 1'b0;
            err_d     = err0_q;
            if (din_reg_q >= err_q) begin
                dout_d = 1'b1;
                err_d  = err1_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                din_reg_q <= '0;
                err_q     <= '0;
                err0_q    <= '0;
                err1_q    <= '0;
                dout_q    <= 1'b0;
            end else begin
                din_reg_q <= din_reg_d;
                err_q     <= err_d;
                err0_q    <= err0_d;
                err1_q    <= err1_d;
                dout_q    <= dout_d;
            end
        end

        assign err_w[ch]  = err_q;
        assign dout_w[ch] = dout_q;
    end

    // Only the two assigned pixels carry data; everything else stays dark
    always_comb begin
        ledbits_d               = '0;
        ledbits_d[4'(LED_A)]    = dout_w[0];
        ledbits_d[4'(LED_B)]    = dout_w[1];
    end

    // Matrix index k = scan[8:5]; outputs latch once per index at the strobe
    assign k_c = scan_q[8:5];

    always_comb begin
        scan_d = scan_q + SW'(1);
        aled_d = aled_q;
        kled_d = kled_q;
        if (scan_q[4:0] == 5'd15) begin
            kled_d = ledbits_q[k_c] ? (4'b0001 << k_c[3:2]) : 4'b0000;
            aled_d = ~(4'b0001 << k_c[1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledbits_q <= '0;
            scan_q    <= '0;
            aled_q    <= 4'b1111;
            kled_q    <= 4'b0000;
        end else begin
            ledbits_q <= ledbits_d;
            scan_q    <= scan_d;
            aled_q    <= aled_d;
            kled_q    <= kled_d;
        end
    end

    assign disp_if.saw_out  = saw_q;
    assign disp_if.pdm_a    = dout_w[0];
    assign disp_if.pdm_b    = dout_w[1];
    assign disp_if.err_a    = err_w[0];
    assign disp_if.err_b    = err_w[1];
    assign disp_if.aled     = aled_q;
    assign disp_if.kled_tri = kled_q;

endmodule

// File: tb/tb_pdm_led_display.sv
// Scoreboard bench for pdm_led_display: random channel-B samples, a
// sequence-level reference model, and a decoupled output monitor.
module tb_pdm_led_display;

    localparam int NB     = 10;
    localparam int CLKDIV = 3;
    localparam int LED_A  = 5;
    localparam int LED_B  = 10;
    localparam int MAXV   = 1023;
    localparam int HN     = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pdm_led_display_if #(.NBITS(NB)) bus ();

    pdm_led_display #(
        .NBITS (NB),
        .CLKDIV(CLKDIV),
        .LED_A (LED_A),
        .LED_B (LED_B)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .disp_if(bus)
    );

    typedef struct {
        int t;
        int saw;
        int pa;
        int pb;
        int ea;
        int eb;
        int aled;
        int kled;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    bit   armed = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   nprint = 0;

    // Sequences indexed by edges since reset release
    int t = 0;
    int xa [HN];
    int xb [HN];
    int ea [HN];
    int eb [HN];
    int oa [HN];
    int ob [HN];

    function automatic int amp_at(int s);
        return (MAXV - s / (CLKDIV + 1)) & MAXV;
    endfunction

    function automatic int saw_at(int s);
        return (s == 0) ? MAXV : amp_at(s - 1);
    endfunction

    // din_reg after edge s is the input presented at edge s (0 out of reset)
    function automatic int dreg_a(int s);
        return (s <= 0) ? 0 : xa[s];
    endfunction

    function automatic int dreg_b(int s);
        return (s <= 0) ? 0 : xb[s];
    endfunction

    // e[t] picks between e[t-2]+max-d[t-2] and e[t-2]-d[t-2] by d[t-1]>=e[t-1]
    function automatic int next_err(int tt, int d1, int d2, int e1, int e2);
        if (tt == 1) return 0;
        return (d1 >= e1) ? ((e2 + MAXV - d2) & MAXV) : ((e2 - d2) & MAXV);
    endfunction

    function automatic int ledbit(int s, int k);
        if (s <= 0) return 0;
        if (k == LED_A) return oa[s - 1];
        if (k == LED_B) return ob[s - 1];
        return 0;
    endfunction

    function automatic exp_t expect_at(int tt);
        exp_t e;
        int   u;
        int   k;
        e.t   = tt;
        e.saw = saw_at(tt);
        e.pa  = oa[tt];
        e.pb  = ob[tt];
        e.ea  = ea[tt];
        e.eb  = eb[tt];
        if (tt < 16) begin
            e.aled = 4'hF;
            e.kled = 0;
        end else begin
            u      = tt - ((tt - 16) % 32);
            k      = ((u - 1) >> 5) & 15;
            e.kled = ledbit(u - 1, k) ? (1 << (k >> 2)) : 0;
            e.aled = (~(1 << (k & 3))) & 15;
        end
        return e;
    endfunction

    task automatic model_reset();
        t     = 0;
        ea[0] = 0;
        eb[0] = 0;
        oa[0] = 0;
        ob[0] = 0;
    endtask

    // Drive one sample for the coming edge and queue the expected outputs
    task automatic step(int din);
        bus.din_b = NB'(din);
        t     = t + 1;
        xb[t] = din;
        xa[t] = saw_at(t - 1);
        oa[t] = (dreg_a(t - 1) >= ea[t - 1]) ? 1 : 0;
        ob[t] = (dreg_b(t - 1) >= eb[t - 1]) ? 1 : 0;
        ea[t] = next_err(t, dreg_a(t - 1), dreg_a(t - 2), ea[t - 1], (t >= 2) ? ea[t - 2] : 0);
        eb[t] = next_err(t, dreg_b(t - 1), dreg_b(t - 2), eb[t - 1], (t >= 2) ? eb[t - 2] : 0);
        q.push_back(expect_at(t));
    endtask

    task automatic cycle(int din);
        @(negedge clk);
        step(din);
    endtask

    // Called just after a falling edge: checks the asynchronous response
    // immediately, holds reset for n rising edges, then releases.
    task automatic reset_pulse(int n, int din0);
        armed = 1'b1;
        rst   = 1'b1;
        model_reset();
        q.push_back(expect_at(0));
        ->chk_ev;
        #2;
        q.push_back(expect_at(0));
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            q.push_back(expect_at(0));
        end
        @(negedge clk);
        rst = 1'b0;
        step(din0);
    endtask

    task automatic chk(string name, int tt, int act, int expv);
        vectors = vectors + 1;
        if (act != expv) begin
            miscompares = miscompares + 1;
            if (nprint < 20) begin
                nprint = nprint + 1;
                $display("FAIL %s at edge %0d: got %0d expected %0d", name, tt, act, expv);
            end
        end
    endtask

    // Monitor: one expected entry per rising edge, plus one per reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (armed) begin
                if (q.size() == 0) begin
                    vectors     = vectors + 1;
                    miscompares = miscompares + 1;
                    $display("FAIL scoreboard_empty at time %0t: got 0 entries expected 1", $time);
                end else begin
                    e = q.pop_front();
                    chk("saw_out",  e.t, int'(bus.saw_out),  e.saw);
                    chk("pdm_a",    e.t, int'(bus.pdm_a),    e.pa);
                    chk("pdm_b",    e.t, int'(bus.pdm_b),    e.pb);
                    chk("err_a",    e.t, int'(bus.err_a),    e.ea);
                    chk("err_b",    e.t, int'(bus.err_b),    e.eb);
                    chk("aled",     e.t, int'(bus.aled),     e.aled);
                    chk("kled_tri", e.t, int'(bus.kled_tri), e.kled);
                end
            end
        end
    end

    initial begin
        bus.din_b = '0;
        @(negedge clk);
        reset_pulse(3, 0);
        repeat (39)  cycle(0);
        repeat (600) cycle(MAXV);
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 7))
                0:       cycle(0);
                1:       cycle(MAXV);
                default: cycle(int'($urandom_range(0, MAXV)));
            endcase
        end
        while ((t % 512) != 200) cycle(int'($urandom_range(0, MAXV)));
        @(negedge clk);
        reset_pulse(2, int'($urandom_range(0, MAXV)));
        repeat (700) cycle(int'($urandom_range(0, MAXV)));
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
